// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared widths and halt FSM encoding for the write-back stage
package wb_regfile_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int SEL_W    = 3;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_reg_word.sv
// rtl/wb_reg_word.sv - one DATA_W-bit architectural register with write enable and sync reset
module wb_reg_word
  import wb_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] word_d;

  always_comb begin
    word_d = word_q;
    if (we) begin
      word_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign q = word_q;

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back select, 8x16 register file and halt FSM (option: WB_REGFILE_BYPASS_EN)
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] memDataOut,
  input  logic [DATA_W-1:0] ALUDataOut,
  input  logic              memToRegOut,
  input  logic              regWriteOut,
  input  logic [SEL_W-1:0]  writeRegSel,
  input  logic              haltWB,
  input  logic [SEL_W-1:0]  read1RegSel,
  input  logic [SEL_W-1:0]  read2RegSel,
  output logic [DATA_W-1:0] read1Data,
  output logic [DATA_W-1:0] read2Data,
  output logic [DATA_W-1:0] writeData,
  output logic              halted,
  output logic              err
);

  wb_state_e         state_q;
  wb_state_e         state_d;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_en;

  assign writeData = memToRegOut ? memDataOut : ALUDataOut;

  // Unknown control freezes both the register file and the halt FSM for the cycle.
  assign err   = ((^{regWriteOut, memToRegOut, haltWB}) === 1'bx);
  assign wr_en = regWriteOut && (state_q == ST_RUN) && !err;

  always_comb begin
    state_d = state_q;
    if ((state_q == ST_RUN) && haltWB && !err) begin
      state_d = ST_HALTED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign halted = (state_q == ST_HALTED);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
    wb_reg_word u_word (
      .clk (clk),
      .rst (rst),
      .we  (wr_en && (writeRegSel == SEL_W'(i))),
      .d   (writeData),
      .q   (regs[i])
    );
  end

`ifdef WB_REGFILE_BYPASS_EN
  assign read1Data = (wr_en && (read1RegSel == writeRegSel)) ? writeData : regs[read1RegSel];
  assign read2Data = (wr_en && (read2RegSel == writeRegSel)) ? writeData : regs[read2RegSel];
`else
  assign read1Data = regs[read1RegSel];
  assign read2Data = regs[read2RegSel];
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - randomized self-checking bench for wb_regfile against an array model
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] memDataOut;
  logic [15:0] ALUDataOut;
  logic        memToRegOut;
  logic        regWriteOut;
  logic [2:0]  writeRegSel;
  logic        haltWB;
  logic [2:0]  read1RegSel;
  logic [2:0]  read2RegSel;
  logic [15:0] read1Data;
  logic [15:0] read2Data;
  logic [15:0] writeData;
  logic        halted;
  logic        err;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] mregs [8];
  bit          mhalted;

  wb_regfile dut (
    .clk         (clk),
    .rst         (rst),
    .memDataOut  (memDataOut),
    .ALUDataOut  (ALUDataOut),
    .memToRegOut (memToRegOut),
    .regWriteOut (regWriteOut),
    .writeRegSel (writeRegSel),
    .haltWB      (haltWB),
    .read1RegSel (read1RegSel),
    .read2RegSel (read2RegSel),
    .read1Data   (read1Data),
    .read2Data   (read2Data),
    .writeData   (writeData),
    .halted      (halted),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_wdata();
    return memToRegOut ? memDataOut : ALUDataOut;
  endfunction

  function automatic logic [15:0] exp_read(input logic [2:0] sel);
`ifdef WB_REGFILE_BYPASS_EN
    if (regWriteOut === 1'b1 && !mhalted && sel == writeRegSel) return exp_wdata();
`endif
    return mregs[sel];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
      mhalted = 1'b0;
    end else if (!$isunknown({regWriteOut, memToRegOut, haltWB}) && !mhalted) begin
      if (regWriteOut) mregs[writeRegSel] = exp_wdata();
      if (haltWB) mhalted = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; regWriteOut = 1'b0; memToRegOut = 1'b0; haltWB = 1'b0;
    memDataOut = 16'h0; ALUDataOut = 16'h0; writeRegSel = 3'd0;
  endtask

  task automatic write_cycle(input logic m2r, input logic [15:0] data, input logic [2:0] sel,
                             input logic halt);
    regWriteOut = 1'b1; memToRegOut = m2r; writeRegSel = sel; haltWB = halt;
    memDataOut  = m2r ? data : 16'h5555;
    ALUDataOut  = m2r ? 16'hAAAA : data;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      read1RegSel = 3'(i); read2RegSel = 3'(7 - i); #1;
      n_checks += 2;
      if (read1Data !== 16'h0000) begin n_fail++; $display("FAIL reset_rd1[%0d] got %h exp 0000", i, read1Data); end
      if (read2Data !== 16'h0000) begin n_fail++; $display("FAIL reset_rd2[%0d] got %h exp 0000", 7 - i, read2Data); end
    end
    n_checks += 2;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b exp 0", halted); end
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
  endtask

  task automatic test_directed_write();
    write_cycle(1'b0, 16'h1234, 3'd3, 1'b0);
    tick(); idle();
    read1RegSel = 3'd3; #1;
    n_checks++;
    if (read1Data !== 16'h1234) begin n_fail++; $display("FAIL alu_write got %h exp 1234", read1Data); end
    write_cycle(1'b1, 16'hBEEF, 3'd5, 1'b0); #1;
    n_checks++;
    if (writeData !== 16'hBEEF) begin n_fail++; $display("FAIL mem_wdata got %h exp beef", writeData); end
    tick(); idle();
    read2RegSel = 3'd5; #1;
    n_checks++;
    if (read2Data !== 16'hBEEF) begin n_fail++; $display("FAIL mem_write got %h exp beef", read2Data); end
  endtask

  task automatic test_bypass();
    logic [15:0] expv;
    write_cycle(1'b0, 16'h0001, 3'd2, 1'b0);
    tick();
    write_cycle(1'b0, 16'hA5A5, 3'd2, 1'b0);
    read1RegSel = 3'd2; #1;
`ifdef WB_REGFILE_BYPASS_EN
    expv = 16'hA5A5;
`else
    expv = 16'h0001;
`endif
    n_checks++;
    if (read1Data !== expv) begin n_fail++; $display("FAIL bypass_rd1 got %h exp %h", read1Data, expv); end
    tick(); idle(); #1;
    n_checks++;
    if (read1Data !== 16'hA5A5) begin n_fail++; $display("FAIL bypass_commit got %h exp a5a5", read1Data); end
  endtask

  task automatic test_random(input int cycles);
    logic [15:0] e1, e2, ew;
    for (int c = 0; c < cycles; c++) begin
      rst = 1'b0; haltWB = 1'b0;
      regWriteOut = 1'($urandom_range(0, 1));
      memToRegOut = 1'($urandom_range(0, 1));
      memDataOut  = 16'($urandom);
      ALUDataOut  = 16'($urandom);
      writeRegSel = 3'($urandom_range(0, 7));
      read1RegSel = 3'($urandom_range(0, 7));
      read2RegSel = ($urandom_range(0, 3) == 0) ? read1RegSel : 3'($urandom_range(0, 7));
      #1;
      e1 = exp_read(read1RegSel); e2 = exp_read(read2RegSel); ew = exp_wdata();
      n_checks += 4;
      if (writeData !== ew) begin n_fail++; $display("FAIL rand_wdata c%0d got %h exp %h", c, writeData, ew); end
      if (read1Data !== e1) begin n_fail++; $display("FAIL rand_rd1 c%0d sel %0d got %h exp %h", c, read1RegSel, read1Data, e1); end
      if (read2Data !== e2) begin n_fail++; $display("FAIL rand_rd2 c%0d sel %0d got %h exp %h", c, read2RegSel, read2Data, e2); end
      if (err !== 1'b0) begin n_fail++; $display("FAIL rand_err c%0d got %b exp 0", c, err); end
      tick();
    end
    idle();
  endtask

  task automatic test_halt();
    logic [15:0] e1;
    write_cycle(1'b0, 16'h7777, 3'd1, 1'b1);
    tick(); idle();
    read1RegSel = 3'd1; #1;
    n_checks += 2;
    if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag got %b exp 1", halted); end
    if (read1Data !== 16'h7777) begin n_fail++; $display("FAIL halt_commit got %h exp 7777", read1Data); end
    write_cycle(1'b0, 16'h9999, 3'd1, 1'b0);
    read1RegSel = 3'd1; #1;
    n_checks++;
    if (read1Data !== 16'h7777) begin n_fail++; $display("FAIL halt_nobypass got %h exp 7777", read1Data); end
    tick();
    for (int c = 0; c < 20; c++) begin
      write_cycle(1'($urandom_range(0, 1)), 16'($urandom), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)));
      tick();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      read1RegSel = 3'(i); read2RegSel = 3'(i); #1;
      e1 = mregs[i];
      n_checks += 2;
      if (read1Data !== e1) begin n_fail++; $display("FAIL halt_hold_rd1[%0d] got %h exp %h", i, read1Data, e1); end
      if (read2Data !== e1) begin n_fail++; $display("FAIL halt_hold_rd2[%0d] got %h exp %h", i, read2Data, e1); end
    end
    n_checks++;
    if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_stays got %b exp 1", halted); end
  endtask

  task automatic test_reset_from_halt();
    idle(); rst = 1'b1;
    tick(); rst = 1'b0;
    n_checks++;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL unhalt got %b exp 0", halted); end
    for (int i = 0; i < 8; i++) begin
      read1RegSel = 3'(i); #1;
      n_checks++;
      if (read1Data !== 16'h0000) begin n_fail++; $display("FAIL unhalt_clear[%0d] got %h exp 0000", i, read1Data); end
    end
    write_cycle(1'b1, 16'h4C4C, 3'd4, 1'b0);
    tick(); idle();
    read2RegSel = 3'd4; #1;
    n_checks++;
    if (read2Data !== 16'h4C4C) begin n_fail++; $display("FAIL post_reset_write got %h exp 4c4c", read2Data); end
  endtask

  task automatic test_reset_priority();
    write_cycle(1'b0, 16'h0F0F, 3'd0, 1'b0);
    tick();
    write_cycle(1'b0, 16'hFFFF, 3'd0, 1'b1);
    rst = 1'b1;
    tick(); idle();
    read1RegSel = 3'd0; #1;
    n_checks += 2;
    if (read1Data !== 16'h0000) begin n_fail++; $display("FAIL rst_prio got %h exp 0000", read1Data); end
    if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_prio_halt got %b exp 0", halted); end
  endtask

  task automatic test_err();
    logic        xin;
    logic [15:0] e1;
    write_cycle(1'b0, 16'h3C3C, 3'd6, 1'b0);
    tick();
    write_cycle(1'b0, 16'hDEAD, 3'd6, 1'b0);
    regWriteOut = 1'bx; #1;
    xin = $isunknown(regWriteOut);
    n_checks++;
    if (err !== xin) begin n_fail++; $display("FAIL err_flag got %b exp %b", err, xin); end
    tick(); idle();
    read1RegSel = 3'd6; #1;
    e1 = mregs[6];
    n_checks += 2;
    if (read1Data !== e1) begin n_fail++; $display("FAIL err_nowrite got %h exp %h", read1Data, e1); end
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b exp 0", err); end
  endtask

  initial begin
    idle();
    read1RegSel = 3'd0; read2RegSel = 3'd0;
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
    mhalted = 1'b0;
    test_reset();
    test_directed_write();
    test_bypass();
    test_random(300);
    test_halt();
    test_reset_from_halt();
    test_random(100);
    test_reset_priority();
    test_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM/WB pipeline boundary: consumes the registered MEM/WB outputs, selects write-back data, and commits it to an 8-entry x 16-bit general register file.
- Provides the two decode-stage read ports.
- Includes a small halt FSM so that a HALT instruction retiring through WB freezes architectural state.

Parameters:
- DATA_W, 16, register and data width
- NUM_REGS, 8, number of architectural registers
- SEL_W, 3, register-select width (log2 NUM_REGS)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- memDataOut  in  16  load data from MEM/WB
- ALUDataOut  in  16  ALU result from MEM/WB
- memToRegOut  in  1  1 = write memDataOut, 0 = write ALUDataOut
- regWriteOut  in  1  write enable from MEM/WB
- writeRegSel  in  3  destination register
- haltWB  in  1  HALT instruction is in WB this cycle
- read1RegSel  in  3  read port 1 select
- read2RegSel  in  3  read port 2 select
- read1Data  out  16  read port 1 data
- read2Data  out  16  read port 2 data
- writeData  out  16  selected write-back data (combinational, for EX forwarding)
- halted  out  1  architectural state frozen
- err  out  1  X/invalid control detected

Behaviour:
- One clock, named clk; reset named rst, synchronous, active-high. A rising edge with rst=1 clears every register to 16'h0000, sets FSM to RUN, halted=0, err=0.
- writeData = memToRegOut ? memDataOut : ALUDataOut. Zero latency.
- Write: at the rising edge, if regWriteOut=1 and the state permits, reg[writeRegSel] <= writeData. Write latency is 1 cycle.
- Reads are combinational: readNData = reg[readNRegSel].
- Bypass: see Optional Feature.
- FSM states:
  - RUN: writes are permitted. If haltWB=1, the write in the same cycle is still committed and the next state is HALTED.
  - HALTED: all writes are ignored and halted=1. Reads still return stored values. Exit only via rst.
- haltWB=1 while already HALTED: no effect.
- Simultaneous rst and regWriteOut/haltWB: rst wins; no write occurs.
- err=1 (combinational) when regWriteOut, memToRegOut or haltWB is X/Z. The register file does not change on a cycle in which err=1.
- Two read ports selecting the same register must return identical data.

Optional Feature:
- Macro WB_REGFILE_BYPASS_EN.
- Defined: if regWriteOut=1, the state is RUN, and readNRegSel==writeRegSel, then readNData = writeData in the same cycle (write-before-read).
- Undefined: reads always return the stored value. The hazard unit must insert one extra stall cycle.

Decomposition:
- Shared package/include holds DATA_W, SEL_W, NUM_REGS, and the FSM state encodings (RUN=1'b0, HALTED=1'b1). EX/MEM and MEM/WB reuse DATA_W.
- One natural sub-module, wb_reg_word: a DATA_W-bit register with write enable and synchronous reset, built from the team dff. It is instantiated NUM_REGS times.

Test Plan:
- Reset, then read all 8 registers on both ports -> all 16'h0000, halted=0, err=0.
- regWriteOut=1, memToRegOut=0, ALUDataOut=16'h1234, writeRegSel=3; next cycle read1RegSel=3 -> read1Data=16'h1234. Repeat with memToRegOut=1, memDataOut=16'hBEEF, reg 5 -> read2Data=16'hBEEF, and writeData=16'hBEEF in the write cycle.
- Same-cycle write 16'hA5A5 to reg 2 while read1RegSel=2 (reg 2 previously 16'h0001) -> with WB_REGFILE_BYPASS_EN read1Data=16'hA5A5; without it read1Data=16'h0001.
- haltWB=1 together with a write of 16'h7777 to reg 1 -> reg 1=16'h7777, halted=1 next cycle; a later write of 16'h9999 to reg 1 is ignored, and reg 1 reads 16'h7777.
- While HALTED, assert rst -> halted=0 and all registers 16'h0000 the next cycle; a write to reg 4 then succeeds.
- rst=1 together with regWriteOut=1 writing 16'hFFFF to reg 0 -> reg 0 reads 16'h0000. regWriteOut=X -> err=1 and no register changes.
